core_bus_target: RTL and testbench
==================================

CORE_BUS_TARGET -- requirements
Module: core_bus_target

Interface
REQ-001 Parameter RAM_AWIDTH, default 11, word-address width of the on-chip RAM (2K words).
REQ-002 Parameter IO_PAGE, default 8'hFF, value of ADDR[15:8] that selects the I/O register page.
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ADDR  input  16  byte address from core (ADDR_BUF).
REQ-006 DOUT  input  16  write data from core (DOUT_BUF).
REQ-007 DIN  output  16  read data to core.
REQ-008 RDN  input  1  read strobe, active-low.
REQ-009 WRN0  input  1  low-byte write strobe, active-low, lane bits 7:0.
REQ-010 WRN1  input  1  high-byte write strobe, active-low, lane bits 15:8.
REQ-011 ABUS_OEN  input  1  bus valid, active-low; strobes are ignored while it is high.
REQ-012 EXT_IRQ  input  1  asynchronous external interrupt source, rising-edge sensitive.
REQ-013 INT0  output  1  timer interrupt request to core, registered.
REQ-014 INT1  output  1  external interrupt request to core, registered.

Function
REQ-015 Decode: RAM when ADDR < 2^(RAM_AWIDTH+1), word index ADDR[RAM_AWIDTH:1]; I/O when ADDR[15:8]==IO_PAGE; all other addresses unmapped. ADDR[0] is ignored.
REQ-016 Write: commits exactly once per strobe assertion. Commit occurs in the first cycle where ABUS_OEN=0 and (WRN0 or WRN1)=0 after both were high. Strobes held low for several cycles do not re-write.
REQ-017 Byte lanes: WRN0 low writes bits 7:0 and WRN1 low writes bits 15:8; both low writes the full word. This applies to RAM and I/O registers alike.
REQ-018 Read: while ABUS_OEN=0 and RDN=0, DIN is registered from the decoded source, valid one cycle after RDN falls. DIN holds its last value while RDN is high.
REQ-019 Unmapped space: reads return 16'h0000; writes are ignored.
REQ-020 If RDN and a write strobe are low in the same cycle, the write commits and DIN holds.
REQ-021 I/O map (offsets within the page):
  - 0x00 CTRL: bit0 EN, bit1 AUTO, bit2 IE0, bit3 IE1.
  - 0x02 RELOAD.
  - 0x04 COUNT (read-only).
  - 0x06 STATUS: bit0 TPEND, bit1 XPEND; write-1-to-clear.
  - All other offsets read 0 and ignore writes.
REQ-022 Timer start: a write that changes EN from 0 to 1 loads COUNT from RELOAD in the same commit.
REQ-023 Timer run: while EN=1, COUNT decrements by 1 each cycle. On the cycle COUNT==0:
  - TPEND is set;
  - if AUTO=1, COUNT reloads from RELOAD;
  - if AUTO=0, EN clears and COUNT stays 0.
REQ-024 RELOAD written while the timer runs takes effect at the next reload only. With RELOAD=0 and AUTO=1, TPEND is set every cycle.
REQ-025 EXT_IRQ passes through a 2-flop synchronizer; a synchronized 0->1 transition sets XPEND.
REQ-026 When a set and a W1C clear of the same pending bit land in the same cycle, the set wins.
REQ-027 INT0 = registered (TPEND & IE0); INT1 = registered (XPEND & IE1). Each asserts one cycle after the pending bit sets.

Reset
REQ-028 While RESET is high, the following are 0 asynchronously: DIN, INT0, INT1, CTRL, RELOAD, COUNT, STATUS, synchronizer flops and write-edge flags.
REQ-029 RAM contents are not reset.
REQ-030 Reset asserted mid-transfer aborts the transfer. A strobe still low when RESET falls does not commit; it must rise and fall again.

Structure
REQ-031 Package bus_target_pkg holds the I/O register offsets, CTRL/STATUS bit positions and the region-decode enum (RAM, IO, NONE).
REQ-032 Sub-module bus_ram: synchronous single-port RAM, depth 2^RAM_AWIDTH x 16, per-byte write enables, registered read. Its read latency forms the one-cycle DIN latency.
REQ-033 The timer, interrupt logic and decode live in core_bus_target.

Verification
REQ-034 Word write ADDR=0x0010, DOUT=0x1234, WRN0=WRN1=0, then read 0x0010 -> DIN=0x1234 one cycle after RDN falls.
REQ-035 Write 0xABCD to 0x0020, then a byte write DOUT=0x55xx with only WRN1 low -> read returns 0x55CD. Holding WRN0 low for 5 cycles produces only a single commit.
REQ-036 RELOAD=3, CTRL=0x5 (EN, IE0) -> COUNT steps 3,2,1,0; TPEND sets; INT0=1 the following cycle; EN clears. Writing STATUS=0x1 drops INT0.
REQ-037 CTRL=0x7 with RELOAD=2 -> TPEND is set every 3 cycles. A W1C write on a cycle that coincides with a set leaves TPEND=1.
REQ-038 CTRL=0x8, EXT_IRQ pulsed 0->1 -> XPEND sets, then INT1=1. Holding EXT_IRQ high does not re-set XPEND after a clear.
REQ-039 Read of 0x8000 (unmapped) -> DIN=0x0000. Read of 0xFF0A -> DIN=0x0000. RESET pulsed mid-timer -> all outputs are 0 and COUNT=0.

Source files
------------

// File: rtl/bus_target_pkg.sv
// Shared definitions for the core bus target: address decode regions,
// I/O register offsets, control/status bit positions and a byte-lane merge.
package bus_target_pkg;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_IO,
      REGION_NONE
   } region_e;

   // Offsets within the I/O page (bit 0 of the address is never decoded)
   localparam logic [7:0] OFF_CTRL   = 8'h00;
   localparam logic [7:0] OFF_RELOAD = 8'h02;
   localparam logic [7:0] OFF_COUNT  = 8'h04;
   localparam logic [7:0] OFF_STATUS = 8'h06;

   // CTRL bit positions
   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_AUTO = 1;
   localparam int unsigned CTRL_IE0  = 2;
   localparam int unsigned CTRL_IE1  = 3;
   localparam int unsigned CTRL_W    = 4;

   // STATUS bit positions
   localparam int unsigned ST_TPEND = 0;
   localparam int unsigned ST_XPEND = 1;
   localparam int unsigned ST_W     = 2;

   // Replace the byte lanes flagged in lanes[1:0] (bit0 = 7:0, bit1 = 15:8)
   function automatic logic [15:0] lane_merge(input logic [15:0] old_v,
                                              input logic [15:0] new_v,
                                              input logic [1:0]  lanes);
      lane_merge = {lanes[1] ? new_v[15:8] : old_v[15:8],
                    lanes[0] ? new_v[7:0]  : old_v[7:0]};
   endfunction

endpackage

// File: rtl/bus_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. Contents are not reset.
module bus_ram #(
   parameter int unsigned AWIDTH = 11
) (
   input  logic              CLK,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [15:0]       i_wdata,
   input  logic [1:0]        i_we,
   input  logic              i_re,
   output logic [15:0]       o_rdata
);

   localparam int unsigned DEPTH = 1 << AWIDTH;

   logic [15:0] r_mem [DEPTH];
   logic [15:0] r_rdata;

   // Byte-lane writes and registered read; the read register only updates
   // on an enabled read so the output holds between accesses
   always_ff @(posedge CLK) begin
      if (i_we[0]) r_mem[i_addr][7:0]  <= i_wdata[7:0];
      if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
      if (i_re)    r_rdata             <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/core_bus_target.sv
// Bus target for the core: address decode into on-chip RAM and an I/O page
// holding a down-counting timer and two interrupt sources.
module core_bus_target
   import bus_target_pkg::*;
#(
   parameter int unsigned RAM_AWIDTH = 11,
   parameter logic [7:0]  IO_PAGE    = 8'hFF
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] ADDR,
   input  logic [15:0] DOUT,
   output logic [15:0] DIN,
   input  logic        RDN,
   input  logic        WRN0,
   input  logic        WRN1,
   input  logic        ABUS_OEN,
   input  logic        EXT_IRQ,
   output logic        INT0,
   output logic        INT1
);

   // bus qualification and decode
   logic              w_bus;
   logic [1:0]        w_lanes;
   logic              w_wr_act;
   logic              w_commit;
   logic              w_rd_act;
   region_e           w_region;
   logic [7:0]        w_off;
   logic              w_unused_addr0;

   // write-edge tracking and read path
   logic              r_wr_armed;
   region_e           r_rd_src;
   logic [15:0]       r_io_q;
   logic [15:0]       w_io_rdata;
   logic [15:0]       w_ram_q;
   logic [1:0]        w_ram_we;
   logic              w_ram_re;

   // I/O registers
   logic [CTRL_W-1:0] r_ctrl;
   logic [ST_W-1:0]   r_status;
   logic [15:0]       r_reload;
   logic [15:0]       r_count;

   logic              w_wr_ctrl;
   logic              w_wr_reload;
   logic              w_wr_status;
   logic [CTRL_W-1:0] w_ctrl_nxt;
   logic [15:0]       w_count_nxt;
   logic [ST_W-1:0]   w_st_set;
   logic [ST_W-1:0]   w_st_clr;

   // external interrupt synchronizer and edge detect
   logic              r_xirq_meta;
   logic              r_xirq_sync;
   logic              r_xirq_prev;

   logic              r_int0;
   logic              r_int1;

   assign w_unused_addr0 = ADDR[0];

   assign w_bus    = ~ABUS_OEN;
   assign w_lanes  = {~WRN1, ~WRN0} & {2{w_bus}};
   assign w_wr_act = |w_lanes;
   // A write commits only when the strobes were seen inactive at an earlier
   // edge; the arm flag resets to 0 so a strobe held across reset never commits.
   assign w_commit = w_wr_act & r_wr_armed;
   // A write strobe suppresses the read so DIN holds during the write
   assign w_rd_act = w_bus & ~RDN & ~w_wr_act;
   assign w_off    = {ADDR[7:1], 1'b0};

   // Region decode: RAM takes priority, then the I/O page, else unmapped
   always_comb begin
      w_region = REGION_NONE;
      if (ADDR[15:RAM_AWIDTH+1] == '0)
         w_region = REGION_RAM;
      else if (ADDR[15:8] == IO_PAGE)
         w_region = REGION_IO;
   end

   assign w_wr_ctrl   = w_commit & (w_region == REGION_IO) & (w_off == OFF_CTRL) & w_lanes[0];
   assign w_wr_reload = w_commit & (w_region == REGION_IO) & (w_off == OFF_RELOAD);
   assign w_wr_status = w_commit & (w_region == REGION_IO) & (w_off == OFF_STATUS) & w_lanes[0];

   assign w_ram_we = w_lanes & {2{w_commit & (w_region == REGION_RAM)}};
   assign w_ram_re = w_rd_act & (w_region == REGION_RAM);

   bus_ram #(
      .AWIDTH (RAM_AWIDTH)
   ) u_ram (
      .CLK     (CLK),
      .i_addr  (ADDR[RAM_AWIDTH:1]),
      .i_wdata (DOUT),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .o_rdata (w_ram_q)
   );

   // I/O page read mux; unlisted offsets read as zero
   always_comb begin
      w_io_rdata = '0;
      case (w_off)
         OFF_CTRL:   w_io_rdata[CTRL_W-1:0] = r_ctrl;
         OFF_RELOAD: w_io_rdata             = r_reload;
         OFF_COUNT:  w_io_rdata             = r_count;
         OFF_STATUS: w_io_rdata[ST_W-1:0]   = r_status;
         default:    w_io_rdata             = '0;
      endcase
   end

   // Timer step with CTRL writes layered on top: a written CTRL value wins
   // over the auto-clear of EN, and an EN 0->1 write loads COUNT from RELOAD
   always_comb begin
      w_ctrl_nxt  = r_ctrl;
      w_count_nxt = r_count;
      w_st_set    = '0;
      if (r_ctrl[CTRL_EN]) begin
         if (r_count == '0) begin
            w_st_set[ST_TPEND] = 1'b1;
            if (r_ctrl[CTRL_AUTO])
               w_count_nxt = r_reload;
            else
               w_ctrl_nxt[CTRL_EN] = 1'b0;
         end else begin
            w_count_nxt = r_count - 16'd1;
         end
      end
      if (w_wr_ctrl) begin
         w_ctrl_nxt = DOUT[CTRL_W-1:0];
         if (DOUT[CTRL_EN] && !r_ctrl[CTRL_EN])
            w_count_nxt = r_reload;
      end
      w_st_set[ST_XPEND] = r_xirq_sync & ~r_xirq_prev;
      w_st_clr = w_wr_status ? DOUT[ST_W-1:0] : '0;
   end

   // Write-edge arm flag: armed whenever no write strobe is active
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_wr_armed <= 1'b0;
      else       r_wr_armed <= ~w_wr_act;
   end

   // Read capture: remember which source was read and latch I/O data
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rd_src <= REGION_NONE;
         r_io_q   <= '0;
      end else if (w_rd_act) begin
         r_rd_src <= w_region;
         r_io_q   <= w_io_rdata;
      end
   end

   // DIN selects between the RAM read register and the I/O read register
   always_comb begin
      case (r_rd_src)
         REGION_RAM: DIN = w_ram_q;
         REGION_IO:  DIN = r_io_q;
         default:    DIN = '0;
      endcase
   end

   // Timer and I/O register state; pending bits: set wins over W1C clear
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ctrl   <= '0;
         r_reload <= '0;
         r_count  <= '0;
         r_status <= '0;
      end else begin
         r_ctrl   <= w_ctrl_nxt;
         r_count  <= w_count_nxt;
         r_status <= (r_status & ~w_st_clr) | w_st_set;
         if (w_wr_reload)
            r_reload <= lane_merge(r_reload, DOUT, w_lanes);
      end
   end

   // Two-flop synchronizer for EXT_IRQ plus a flop for rising-edge detect
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_xirq_meta <= 1'b0;
         r_xirq_sync <= 1'b0;
         r_xirq_prev <= 1'b0;
      end else begin
         r_xirq_meta <= EXT_IRQ;
         r_xirq_sync <= r_xirq_meta;
         r_xirq_prev <= r_xirq_sync;
      end
   end

   // Registered interrupt requests from pending bits gated by enables
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_int0 <= 1'b0;
         r_int1 <= 1'b0;
      end else begin
         r_int0 <= r_status[ST_TPEND] & r_ctrl[CTRL_IE0];
         r_int1 <= r_status[ST_XPEND] & r_ctrl[CTRL_IE1];
      end
   end

   assign INT0 = r_int0;
   assign INT1 = r_int1;

endmodule

// File: tb/tb_core_bus_target.sv
// Self-checking bench for core_bus_target: directed bus transactions, a
// behavioural model compared every cycle, and hand-computed literal checks.
module tb_core_bus_target;

   localparam int unsigned AW = 11;

   logic        CLK      = 1'b0;
   logic        RESET    = 1'b0;
   logic [15:0] ADDR     = '0;
   logic [15:0] DOUT     = '0;
   logic        RDN      = 1'b1;
   logic        WRN0     = 1'b1;
   logic        WRN1     = 1'b1;
   logic        ABUS_OEN = 1'b1;
   logic        EXT_IRQ  = 1'b0;
   logic [15:0] DIN;
   logic        INT0;
   logic        INT1;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   core_bus_target #(
      .RAM_AWIDTH (AW),
      .IO_PAGE    (8'hFF)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .ADDR     (ADDR),
      .DOUT     (DOUT),
      .DIN      (DIN),
      .RDN      (RDN),
      .WRN0     (WRN0),
      .WRN1     (WRN1),
      .ABUS_OEN (ABUS_OEN),
      .EXT_IRQ  (EXT_IRQ),
      .INT0     (INT0),
      .INT1     (INT1)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] mem [int];
   logic [3:0]  m_ctrl   = '0;
   logic [15:0] m_reload = '0;
   logic [15:0] m_count  = '0;
   logic [1:0]  m_status = '0;
   bit          m_idle   = 1'b0;
   logic [15:0] m_din    = '0;
   bit          m_din_ok = 1'b1;
   bit          m_int0   = 1'b0;
   bit          m_int1   = 1'b0;
   int          cyc      = 0;
   int          xq[$];
   bit          last_ext = 1'b0;

   always @(posedge CLK or posedge RESET) begin : model
      bit          bus, rd, commit, isram, isio;
      logic [1:0]  ln, set, clr;
      logic [7:0]  off;
      int          idx;
      logic [3:0]  nctrl;
      logic [15:0] ncount, oldw;
      if (RESET) begin
         m_ctrl = '0; m_reload = '0; m_count = '0; m_status = '0;
         m_idle = 1'b0; m_din = '0; m_din_ok = 1'b1;
         m_int0 = 1'b0; m_int1 = 1'b0;
         xq.delete(); last_ext = 1'b0;
      end else begin
         cyc++;
         bus    = !ABUS_OEN;
         ln     = bus ? {!WRN1, !WRN0} : 2'b00;
         rd     = bus && !RDN && (ln == 2'b00);
         commit = (ln != 2'b00) && m_idle;
         m_idle = (ln == 2'b00);
         isram  = int'(ADDR) < (1 << (AW + 1));
         isio   = !isram && (ADDR[15:8] == 8'hFF);
         off    = {ADDR[7:1], 1'b0};
         idx    = int'(ADDR[AW:1]);
         if (rd) begin
            m_din_ok = 1'b1;
            if (isram) begin
               if (mem.exists(idx)) m_din = mem[idx];
               else m_din_ok = 1'b0;
            end else if (isio) begin
               case (off)
                  8'h00:   m_din = {12'h000, m_ctrl};
                  8'h02:   m_din = m_reload;
                  8'h04:   m_din = m_count;
                  8'h06:   m_din = {14'h0000, m_status};
                  default: m_din = 16'h0000;
               endcase
            end else begin
               m_din = 16'h0000;
            end
         end
         m_int0 = m_status[0] && m_ctrl[2];
         m_int1 = m_status[1] && m_ctrl[3];
         set = 2'b00; clr = 2'b00;
         nctrl = m_ctrl; ncount = m_count;
         if (m_ctrl[0]) begin
            if (m_count == 16'h0000) begin
               set[0] = 1'b1;
               if (m_ctrl[1]) ncount = m_reload;
               else nctrl[0] = 1'b0;
            end else begin
               ncount = m_count - 16'd1;
            end
         end
         if (commit && isram) begin
            oldw = mem.exists(idx) ? mem[idx] : 16'h0000;
            mem[idx] = {ln[1] ? DOUT[15:8] : oldw[15:8], ln[0] ? DOUT[7:0] : oldw[7:0]};
         end
         if (commit && isio) begin
            if (off == 8'h00 && ln[0]) begin
               nctrl = DOUT[3:0];
               if (DOUT[0] && !m_ctrl[0]) ncount = m_reload;
            end
            if (off == 8'h02)
               m_reload = {ln[1] ? DOUT[15:8] : m_reload[15:8], ln[0] ? DOUT[7:0] : m_reload[7:0]};
            if (off == 8'h06 && ln[0]) clr = DOUT[1:0];
         end
         if (xq.size() > 0 && xq[0] == cyc) begin
            void'(xq.pop_front());
            set[1] = 1'b1;
         end
         if (EXT_IRQ && !last_ext) xq.push_back(cyc + 2);
         last_ext = EXT_IRQ;
         m_status = (m_status & ~clr) | set;
         m_ctrl   = nctrl;
         m_count  = ncount;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (chk_on) begin
         if (m_din_ok) check("model_DIN", DIN, m_din);
         check("model_INT0", {15'h0, INT0}, {15'h0, m_int0});
         check("model_INT1", {15'h0, INT1}, {15'h0, m_int1});
      end
   end

   // ---------------- bus tasks (called at a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // lanes_n = {WRN1, WRN0}, active low
   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes_n);
      ADDR = a; DOUT = d; ABUS_OEN = 1'b0; {WRN1, WRN0} = lanes_n;
      @(negedge CLK);
      WRN0 = 1'b1; WRN1 = 1'b1; ABUS_OEN = 1'b1;
      @(negedge CLK);
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      ADDR = a; ABUS_OEN = 1'b0; RDN = 1'b0;
      @(negedge CLK);
      v = DIN;
      RDN = 1'b1; ABUS_OEN = 1'b1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin : stim
      logic [15:0] v;
      #1 RESET = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_DIN", DIN, 16'h0000);
      check("rst_INT0", {15'h0, INT0}, 16'h0000);
      check("rst_INT1", {15'h0, INT1}, 16'h0000);
      RESET = 1'b0;
      chk_on = 1'b1;
      idle(1);

      // word write then read
      wr(16'h0010, 16'h1234, 2'b00);
      rd(16'h0010, v);
      check("ram_word", v, 16'h1234);

      // high-byte write
      wr(16'h0020, 16'hABCD, 2'b00);
      wr(16'h0020, 16'h55EE, 2'b01);
      rd(16'h0020, v);
      check("ram_hibyte", v, 16'h55CD);

      // low strobe held 5 cycles with changing data: single commit
      ADDR = 16'h0020; ABUS_OEN = 1'b0; WRN0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         DOUT = 16'h0011 * 16'(i + 1);
         @(negedge CLK);
      end
      WRN0 = 1'b1; ABUS_OEN = 1'b1;
      idle(1);
      rd(16'h0020, v);
      check("ram_single_commit", v, 16'h5511);

      // one-shot timer: RELOAD=3, CTRL=EN|IE0, continuous COUNT read
      wr(16'hFF02, 16'h0003, 2'b00);
      ADDR = 16'hFF00; DOUT = 16'h0005; ABUS_OEN = 1'b0; WRN0 = 1'b0; WRN1 = 1'b0;
      @(negedge CLK);
      WRN0 = 1'b1; WRN1 = 1'b1; ADDR = 16'hFF04; RDN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("count_step", DIN, 16'(3 - i));
      end
      check("int0_not_yet", {15'h0, INT0}, 16'h0000);
      @(negedge CLK);
      check("int0_set", {15'h0, INT0}, 16'h0001);
      check("count_stays0", DIN, 16'h0000);
      RDN = 1'b1; ABUS_OEN = 1'b1;
      rd(16'hFF06, v);
      check("status_tpend", v, 16'h0001);
      rd(16'hFF00, v);
      check("ctrl_en_cleared", v, 16'h0004);
      wr(16'hFF06, 16'h0001, 2'b00);
      check("int0_w1c", {15'h0, INT0}, 16'h0000);

      // auto-reload timer, W1C coinciding with a set
      wr(16'hFF02, 16'h0002, 2'b00);
      ADDR = 16'hFF00; DOUT = 16'h0007; ABUS_OEN = 1'b0; WRN0 = 1'b0; WRN1 = 1'b0;
      @(negedge CLK);
      WRN0 = 1'b1; WRN1 = 1'b1; ABUS_OEN = 1'b1;
      idle(2);
      wr(16'hFF06, 16'h0001, 2'b00);
      rd(16'hFF06, v);
      check("set_wins_w1c", v, 16'h0001);
      rd(16'hFF04, v);
      check("auto_count0", v, 16'h0000);
      rd(16'hFF04, v);
      check("auto_reload", v, 16'h0002);
      wr(16'hFF00, 16'h0000, 2'b00);
      wr(16'hFF06, 16'h0001, 2'b00);

      // external interrupt
      wr(16'hFF00, 16'h0008, 2'b00);
      EXT_IRQ = 1'b1;
      idle(3);
      check("int1_not_yet", {15'h0, INT1}, 16'h0000);
      idle(1);
      check("int1_set", {15'h0, INT1}, 16'h0001);
      wr(16'hFF06, 16'h0002, 2'b00);
      idle(4);
      check("int1_held_high", {15'h0, INT1}, 16'h0000);
      rd(16'hFF06, v);
      check("xpend_no_reset", v, 16'h0000);
      EXT_IRQ = 1'b0;
      idle(3);
      EXT_IRQ = 1'b1;
      idle(5);
      check("int1_second_edge", {15'h0, INT1}, 16'h0001);
      wr(16'hFF06, 16'h0002, 2'b00);
      EXT_IRQ = 1'b0;
      idle(2);

      // unmapped and boundary addresses
      rd(16'h0010, v);
      wr(16'h8000, 16'hFFFF, 2'b00);
      rd(16'h8000, v);
      check("unmapped_8000", v, 16'h0000);
      rd(16'h0010, v);
      wr(16'hFF0A, 16'hFFFF, 2'b00);
      rd(16'hFF0A, v);
      check("io_hole_FF0A", v, 16'h0000);
      wr(16'h0FFF, 16'h7E57, 2'b00);
      wr(16'h1000, 16'h0BAD, 2'b00);
      rd(16'h0FFE, v);
      check("ram_top_word", v, 16'h7E57);
      rd(16'h1000, v);
      check("unmapped_1000", v, 16'h0000);

      // reset during a running timer and an in-flight write
      wr(16'hFF02, 16'h0005, 2'b00);
      wr(16'hFF00, 16'h0007, 2'b00);
      idle(10);
      check("int0_running", {15'h0, INT0}, 16'h0001);
      rd(16'h0010, v);
      check("ram_before_rst", v, 16'h1234);
      ADDR = 16'h0010; DOUT = 16'hBEEF; ABUS_OEN = 1'b0; WRN0 = 1'b0; WRN1 = 1'b0;
      #2 RESET = 1'b1;
      #1;
      check("async_rst_DIN", DIN, 16'h0000);
      check("async_rst_INT0", {15'h0, INT0}, 16'h0000);
      check("async_rst_INT1", {15'h0, INT1}, 16'h0000);
      idle(2);
      RESET = 1'b0;
      idle(3);
      WRN0 = 1'b1; WRN1 = 1'b1; ABUS_OEN = 1'b1;
      idle(1);
      rd(16'h0010, v);
      check("no_commit_after_rst", v, 16'h1234);
      rd(16'hFF04, v);
      check("count_after_rst", v, 16'h0000);
      rd(16'hFF00, v);
      check("ctrl_after_rst", v, 16'h0000);

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
